// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save accumulating sequencer.
package csa_pkg;

  // Sequencer states; encodings are fixed so they read the same in waveforms and docs.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Width of the operand counter and of res_count.
  localparam int unsigned COUNT_W = 4;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/csa_accum_seq_if.sv
// Operand and result handshakes of the accumulating sequencer, bundled as one interface.
interface csa_accum_seq_if
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_OPS = 8
) ();

  // The accumulator is wide enough that MAX_OPS full-scale operands cannot overflow it.
  localparam int unsigned ACC_W = WIDTH + clog2(MAX_OPS);

  logic               op_valid;
  logic               op_ready;
  logic [WIDTH-1:0]   op_data;
  logic               op_last;
  logic               res_valid;
  logic               res_ready;
  logic [ACC_W-1:0]   res_sum;
  logic [COUNT_W-1:0] res_count;
  logic               res_trunc;
  logic               busy;

  // Producer/consumer side.
  modport master (
    output op_valid, op_data, op_last, res_ready,
    input  op_ready, res_valid, res_sum, res_count, res_trunc, busy
  );

  // Sequencer side.
  modport slave (
    input  op_valid, op_data, op_last, res_ready,
    output op_ready, res_valid, res_sum, res_count, res_trunc, busy
  );

endinterface

// File: rtl/csa_3to2.sv
// Combinational 3:2 carry-save compressor: one full adder per bit, carry left unshifted.
module csa_3to2 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  // Independent full adder per bit position; no carry ripples between bits.
  always_comb begin
    sum   = '0;
    carry = '0;
    for (int i = 0; i < int'(W); i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      carry[i] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

endmodule

// File: rtl/csa_accum_seq.sv
// Accumulates a stream of operands in carry-save form, then resolves them with one
// carry-propagate add and presents the total on a valid/ready result port.
module csa_accum_seq
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MAX_OPS = 8
) (
  input logic            clk,
  input logic            rst,
  csa_accum_seq_if.slave bus
);

  localparam int unsigned ACC_W = WIDTH + clog2(MAX_OPS);

  state_e             state;
  logic [ACC_W-1:0]   sum_vec;
  logic [ACC_W-1:0]   carry_vec;
  logic [COUNT_W-1:0] count;
  logic [ACC_W-1:0]   res_sum;
  logic [COUNT_W-1:0] res_count;
  logic               res_trunc;

  logic               accept;
  logic [COUNT_W-1:0] count_inc;
  logic               hit_max;
  logic [ACC_W-1:0]   csa_a;
  logic [ACC_W-1:0]   csa_b;
  logic [ACC_W-1:0]   csa_c;
  logic [ACC_W-1:0]   csa_sum;
  logic [ACC_W-1:0]   csa_carry;

  // Handshake decode and compressor inputs; IDLE treats the stale vectors as zero.
  always_comb begin
    bus.op_ready  = (state == IDLE) || (state == ACCUM);
    bus.res_valid = (state == DONE);
    bus.busy      = (state != IDLE);
    accept        = bus.op_valid && bus.op_ready;
    count_inc     = count + COUNT_W'(1);
    hit_max       = (32'(count_inc) == MAX_OPS);
    csa_a         = (state == IDLE) ? '0 : sum_vec;
    // The bit shifted out of carry_vec is always zero because ACC_W cannot overflow.
    csa_b         = (state == IDLE) ? '0 : (carry_vec << 1);
    csa_c         = {{(ACC_W - WIDTH){1'b0}}, bus.op_data};
  end

  // Drive result outputs from their holding registers.
  always_comb begin
    bus.res_sum   = res_sum;
    bus.res_count = res_count;
    bus.res_trunc = res_trunc;
  end

  csa_3to2 #(
    .W (ACC_W)
  ) u_csa (
    .a     (csa_a),
    .b     (csa_b),
    .c     (csa_c),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // Sequencer FSM with its accumulator, counter and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sum_vec   <= '0;
      carry_vec <= '0;
      count     <= '0;
      res_sum   <= '0;
      res_count <= '0;
      res_trunc <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            sum_vec   <= csa_sum;
            carry_vec <= csa_carry;
            count     <= count_inc;
            res_trunc <= 1'b0;
            state     <= bus.op_last ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_vec   <= csa_sum;
            carry_vec <= csa_carry;
            count     <= count_inc;
            if (bus.op_last || hit_max) begin
              res_trunc <= !bus.op_last;
              state     <= RESOLVE;
            end
          end
        end
        RESOLVE: begin
          res_sum   <= sum_vec + (carry_vec << 1);
          res_count <= count;
          state     <= DONE;
        end
        DONE: begin
          if (bus.res_ready) begin
            sum_vec   <= '0;
            carry_vec <= '0;
            count     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq: inputs change and outputs are sampled on the falling edge.
module tb_csa_accum_seq;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned MAX_OPS = 8;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  csa_accum_seq_if #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) bus ();

  csa_accum_seq #(
    .WIDTH   (WIDTH),
    .MAX_OPS (MAX_OPS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present one operand for one clock; returns on the following falling edge.
  task automatic send(input logic [3:0] data, input logic last);
    bus.op_valid = 1'b1;
    bus.op_data  = data;
    bus.op_last  = last;
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_last  = 1'b0;
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic check_result(input string tag, input int sum, input int cnt, input logic trunc);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd1);
    check({tag, "_sum"},   32'(bus.res_sum),   32'(sum));
    check({tag, "_count"}, 32'(bus.res_count), 32'(cnt));
    check({tag, "_trunc"}, 32'(bus.res_trunc), 32'(trunc));
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.op_valid  = 1'b0;
    bus.op_data   = '0;
    bus.op_last   = 1'b0;
    bus.res_ready = 1'b0;

    // Reset state.
    #2;
    check("rst_op_ready",  32'(bus.op_ready),  32'd1);
    check("rst_res_valid", 32'(bus.res_valid), 32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_res_sum",   32'(bus.res_sum),   32'd0);
    check("rst_res_count", 32'(bus.res_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single operand with last: result two cycles after acceptance.
    send(4'd9, 1'b1);
    check("t1_resolve_valid", 32'(bus.res_valid), 32'd0);
    check("t1_resolve_busy",  32'(bus.busy),      32'd1);
    @(negedge clk);
    check_result("t1", 9, 1, 1'b0);
    handshake();
    check("t1_after_valid", 32'(bus.res_valid), 32'd0);
    check("t1_after_busy",  32'(bus.busy),      32'd0);

    // Back-to-back 5, 10, 15.
    send(4'd5, 1'b0);
    send(4'd10, 1'b0);
    send(4'd15, 1'b1);
    check("t2_resolve_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    check("t2_done_ready", 32'(bus.op_ready), 32'd0);
    check_result("t2", 30, 3, 1'b0);
    handshake();

    // Eight full-scale operands, never last: forced termination.
    for (int i = 0; i < 8; i++) send(4'd15, 1'b0);
    check("t3_resolve_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    check_result("t3", 120, 8, 1'b1);
    handshake();

    // Gap in op_valid, then a stalled consumer.
    send(4'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("t4_gap_busy", 32'(bus.busy), 32'd1);
    send(4'd7, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("t4_stall_valid", 32'(bus.res_valid), 32'd1);
      check("t4_stall_sum",   32'(bus.res_sum),   32'd10);
      check("t4_stall_ready", 32'(bus.op_ready),  32'd0);
      @(negedge clk);
    end
    check_result("t4", 10, 2, 1'b0);
    handshake();
    check("t4_idle_busy",  32'(bus.busy),     32'd0);
    check("t4_idle_ready", 32'(bus.op_ready), 32'd1);

    // Reset mid-transaction discards everything.
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    rst = 1'b1;
    #1;
    check("t5_rst_busy",  32'(bus.busy),      32'd0);
    check("t5_rst_valid", 32'(bus.res_valid), 32'd0);
    check("t5_rst_ready", 32'(bus.op_ready),  32'd1);
    check("t5_rst_sum",   32'(bus.res_sum),   32'd0);
    check("t5_rst_count", 32'(bus.res_count), 32'd0);
    check("t5_rst_trunc", 32'(bus.res_trunc), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_result", 32'(bus.res_valid), 32'd0);
    send(4'd3, 1'b0);
    send(4'd4, 1'b1);
    @(negedge clk);
    check_result("t5", 7, 2, 1'b0);

    // Operand held during the DONE handshake is taken only in the following IDLE cycle.
    bus.op_valid  = 1'b1;
    bus.op_data   = 4'd1;
    bus.op_last   = 1'b1;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("t6_idle_busy",  32'(bus.busy),     32'd0);
    check("t6_idle_ready", 32'(bus.op_ready), 32'd1);
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op_last  = 1'b0;
    check("t6_resolve_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check_result("t6", 1, 1, 1'b0);
    handshake();
    check("t6_after_valid", 32'(bus.res_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
